// File: rtl/instr_mem_loader.sv
// Instruction memory with a handshaked bulk loader and a combinational fetch port.
// The loader writes a base/count window; fetch checks alignment and range.
module instr_mem_loader #(
  parameter int unsigned     XLEN    = 32,
  parameter int unsigned     DEPTH   = 256,
  parameter int unsigned     AW      = $clog2(DEPTH),
  parameter int unsigned     FADDR_W = 32,
  parameter logic [XLEN-1:0] FILL    = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [AW-1:0]      load_base,
  input  logic [AW:0]        load_count,
  input  logic               load_abort,
  input  logic               load_valid,
  input  logic [XLEN-1:0]    load_data,
  output logic               load_ready,
  output logic               load_busy,
  output logic               load_done,
  output logic [AW:0]        load_words,
  input  logic [FADDR_W-1:0] fetch_addr,
  output logic [XLEN-1:0]    instruction,
  output logic               fetch_err,
  output logic               fetch_stall
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  localparam logic [AW-1:0] PtrOne = 1;
  localparam logic [AW:0]   CntOne = 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     remaining_q, remaining_d;
  logic [AW:0]     words_q, words_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] mem_q [DEPTH];
  logic            accept;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    done_d      = done_q;
    load_ready  = (state_q == StLoad) && !load_abort;
    accept      = load_valid && load_ready;
    case (state_q)
      StIdle, StDone: begin
        if (load_start) begin
          ptr_d       = load_base;
          remaining_d = load_count;
          words_d     = '0;
          // A zero-length load completes immediately without touching the array.
          done_d      = (load_count == '0);
          state_d     = (load_count == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (load_abort) begin
          state_d = StIdle;
        end else if (accept) begin
          ptr_d       = ptr_q + PtrOne;
          remaining_d = remaining_q - CntOne;
          words_d     = words_q + CntOne;
          if (remaining_q == CntOne) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= FILL;
      end
    end else if (accept) begin
      mem_q[ptr_q] <= load_data;
    end
  end

  assign load_busy   = (state_q == StLoad);
  assign load_done   = done_q;
  assign load_words  = words_q;
  assign fetch_stall = load_busy;

  logic [AW-1:0] fetch_idx;
  logic          fetch_hi_err;

  assign fetch_idx = fetch_addr[AW+1:2];

  // Address bits above the array are only present when FADDR_W exceeds AW+2.
  generate
    if (FADDR_W > AW + 2) begin : g_hi
      assign fetch_hi_err = |fetch_addr[FADDR_W-1:AW+2];
    end else begin : g_no_hi
      assign fetch_hi_err = 1'b0;
    end
  endgenerate

  assign fetch_err   = (|fetch_addr[1:0]) | fetch_hi_err;
  assign instruction = fetch_err ? FILL : mem_q[fetch_idx];

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: fetch vector tables, directed load
// sequences and randomized loads checked against an array model.
module tb_instr_mem_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] FILL  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [7:0]  load_base;
  logic [8:0]  load_count;
  logic        load_abort;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_busy;
  logic        load_done;
  logic [8:0]  load_words;
  logic [31:0] fetch_addr;
  logic [31:0] instruction;
  logic        fetch_err;
  logic        fetch_stall;

  instr_mem_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_count  (load_count),
    .load_abort  (load_abort),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_words  (load_words),
    .fetch_addr  (fetch_addr),
    .instruction (instruction),
    .fetch_err   (fetch_err),
    .fetch_stall (fetch_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } fvec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input fvec_t v, input string tag);
    fetch_addr = v.addr;
    #1;
    chk($sformatf("%s_instr@%0h", tag, v.addr), instruction, v.instr);
    chk($sformatf("%s_err@%0h", tag, v.addr), fetch_err, v.err);
  endtask

  task automatic full_check(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      fetch_addr = i * 4;
      #1;
      chk($sformatf("%s_mem[%0d]", tag, i), instruction, model[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = FILL;
  endtask

  // Runs one complete load; mult != 0 gives data mult*(k+1), else random data.
  task automatic do_load(input int base, input int count, input int gap,
                         input logic [31:0] mult, input bit mid_start);
    int          cyc;
    int          written;
    logic [31:0] d;
    tick();
    load_start = 1'b1;
    load_base  = base[7:0];
    load_count = count[8:0];
    load_valid = 1'b1;
    load_data  = 32'hBAD0_0001;
    load_abort = 1'b0;
    #1;
    chk("ready_in_start_cycle", load_ready, 1'b0);
    tick();
    load_start = 1'b0;
    written    = 0;
    cyc        = 1;
    while (written < count && cyc <= count * gap + 4) begin
      load_valid = ((cyc - 1) % gap == 0);
      d          = (mult == 0) ? $urandom : mult * (written + 1);
      load_data  = d;
      load_start = mid_start && (cyc == 2);
      load_count = 9'd1;
      load_base  = 8'd7;
      #1;
      chk("ready_in_load", load_ready, 1'b1);
      chk("busy_in_load", load_busy, 1'b1);
      chk("stall_in_load", fetch_stall, 1'b1);
      chk("words_in_load", load_words, written);
      chk("done_in_load", load_done, 1'b0);
      if (load_valid) begin
        model[(base + written) % DEPTH] = d;
        written++;
      end
      tick();
      cyc++;
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    #1;
    chk("done_after_load", load_done, 1'b1);
    chk("busy_after_load", load_busy, 1'b0);
    chk("ready_after_load", load_ready, 1'b0);
    chk("words_after_load", load_words, count);
    if (gap == 1) chk("load_latency", cyc, count + 1);
    tick();
    chk("done_holds", load_done, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fvec_t rst_vec [4];
    fvec_t ld_vec  [5];
    logic [31:0] d;

    rst_vec[0] = '{addr: 32'h0,   instr: FILL, err: 1'b0};
    rst_vec[1] = '{addr: 32'h3FC, instr: FILL, err: 1'b0};
    rst_vec[2] = '{addr: 32'h2,   instr: FILL, err: 1'b1};
    rst_vec[3] = '{addr: 32'h400, instr: FILL, err: 1'b1};
    ld_vec[0]  = '{addr: 32'h0,         instr: 32'h11, err: 1'b0};
    ld_vec[1]  = '{addr: 32'h8,         instr: 32'h33, err: 1'b0};
    ld_vec[2]  = '{addr: 32'hC,         instr: 32'h44, err: 1'b0};
    ld_vec[3]  = '{addr: 32'hA,         instr: FILL,   err: 1'b1};
    ld_vec[4]  = '{addr: 32'h8000_0004, instr: FILL,   err: 1'b1};

    rst = 1'b1; load_start = 1'b0; load_base = '0; load_count = '0; load_abort = 1'b0;
    load_valid = 1'b0; load_data = '0; fetch_addr = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", load_ready, 1'b0);
    chk("rst_busy", load_busy, 1'b0);
    chk("rst_done", load_done, 1'b0);
    chk("rst_stall", fetch_stall, 1'b0);
    chk("rst_words", load_words, 9'd0);
    foreach (rst_vec[i]) fetch_chk(rst_vec[i], "rst");

    // Back-to-back load of 0x11..0x44 at base 0.
    do_load(0, 4, 1, 32'h11, 1'b0);
    foreach (ld_vec[i]) fetch_chk(ld_vec[i], "load4");

    // Wrap across the top of the array.
    do_load(254, 4, 1, 32'hA0, 1'b0);
    full_check("wrap");

    // Gapped beats with an ignored mid-load start.
    do_load(50, 3, 3, 32'h0, 1'b1);
    full_check("gapped");

    // Zero-length load.
    do_load(9, 0, 1, 32'h0, 1'b0);
    full_check("zero");

    // Abort after 2 of 5 beats; the abort cycle carries a valid beat.
    tick();
    load_start = 1'b1; load_base = 8'd100; load_count = 9'd5;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d = $urandom;
      load_valid = 1'b1;
      load_data  = d;
      model[100 + k] = d;
      tick();
    end
    load_abort = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    #1;
    chk("ready_during_abort", load_ready, 1'b0);
    tick();
    load_abort = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("abort_busy", load_busy, 1'b0);
    chk("abort_done", load_done, 1'b0);
    chk("abort_words", load_words, 9'd2);
    chk("abort_ready", load_ready, 1'b0);
    for (int k = 2; k < 5; k++) begin
      fetch_addr = (100 + k) * 4;
      #1;
      chk($sformatf("abort_untouched[%0d]", 100 + k), instruction, FILL);
    end
    full_check("abort");

    // Reset in the middle of a load.
    tick();
    load_start = 1'b1; load_base = 8'd20; load_count = 9'd6;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'h1234_5678;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("midrst_ready", load_ready, 1'b0);
    chk("midrst_busy", load_busy, 1'b0);
    chk("midrst_done", load_done, 1'b0);
    chk("midrst_stall", fetch_stall, 1'b0);
    chk("midrst_words", load_words, 9'd0);
    model_reset();
    full_check("midrst");

    // Randomized loads against the array model.
    for (int n = 0; n < 12; n++) begin
      int base;
      int count;
      int gap;
      base  = $urandom_range(0, DEPTH - 1);
      count = (n == 5) ? DEPTH : $urandom_range(0, 12);
      gap   = $urandom_range(1, 3);
      do_load(base, count, gap, 32'h0, n[0]);
      full_check($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
